// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and constants for the sequential magnitude-compare controller.
//   state_t      : controller state encoding (IDLE, RUN, DONE), 2 bits
//   DEFAULT_SLICE: default number of operand bits compared per cycle
//   idx_width()  : width of the slice index register for a given slice count
// ---------------------------------------------------------------------------
package cmp_pkg;

    // Controller states; the 2-bit encoding leaves one spare code that the
    // controller treats as a return to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_SLICE = 8;

    // The slice index must address slices 0..nslice-1. A single-slice
    // configuration still keeps a 1-bit register so the port/reg never
    // collapses to zero width.
    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// ---------------------------------------------------------------------------
// cmp_slice
// Purely combinational unsigned comparator for one SLICE-bit slice.
//   a, b : slice operands (unsigned)
//   eq   : a == b
//   gt   : a >  b
//   lt   : a <  b
// Exactly one of eq/gt/lt is high for any input pair.
// ---------------------------------------------------------------------------
module cmp_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    // A plain magnitude compare; synthesis picks the carry-chain structure.
    assign eq = (a == b);
    assign gt = (a >  b);
    assign lt = (a <  b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cmp_seq_ctrl
// Multi-cycle unsigned magnitude-compare controller. One SLICE-bit
// comparator is time-shared across a WIDTH-bit operand pair, walking the
// slices MSB-first and stopping at the first unequal slice.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand pair offered by the producer
//   in_ready  : block can accept operands (IDLE only)
//   a, b      : WIDTH-bit unsigned operands, captured on accept
//   abort     : synchronous cancel while RUN or DONE (ignored in IDLE)
//   out_valid : result valid (DONE only)
//   out_ready : consumer accepts the result
//   eq/gt/lt  : result flags, exactly one high while out_valid is high
//   busy      : operation in progress or result pending (RUN or DONE)
//
// All outputs are either registers or decodes of the state register, so no
// input reaches an output combinationally.
// ---------------------------------------------------------------------------
module cmp_seq_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int NSLICE = (WIDTH / SLICE < 1) ? 1 : WIDTH / SLICE;
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] IDX_LAST = IW'(NSLICE - 1);

    // Reject configurations where the operand cannot be split into whole
    // slices; a partial top slice would silently be compared wrongly.
    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("cmp_seq_ctrl: WIDTH must be a positive integer multiple of SLICE");
    end

    state_t            state;
    logic [IW-1:0]     idx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic [31:0]       base_bit;
    logic [SLICE-1:0]  a_slice;
    logic [SLICE-1:0]  b_slice;
    logic              s_eq;
    logic              s_gt;
    logic              s_lt;

    // Select the slice currently addressed by idx from the captured
    // operands. idx never exceeds NSLICE-1, so the part-select always stays
    // inside the operand.
    always_comb begin
        base_bit = 32'(idx) * 32'(SLICE);
        a_slice  = a_q[base_bit +: SLICE];
        b_slice  = b_q[base_bit +: SLICE];
    end

    // The single shared comparator slice.
    cmp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (a_slice),
        .b  (b_slice),
        .eq (s_eq),
        .gt (s_gt),
        .lt (s_lt)
    );

    // Controller: captures operands on accept, walks idx down from the top
    // slice, latches the flags on the first unequal slice (or equality after
    // the last slice) and holds them in DONE until the consumer takes them.
    // abort outranks both the slice result and out_ready, and always leaves
    // the flags cleared so a cancelled operation never leaks a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        idx   <= IDX_LAST;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        eq    <= 1'b0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        state <= ST_IDLE;
                    end else if (!s_eq) begin
                        eq    <= 1'b0;
                        gt    <= s_gt;
                        lt    <= s_lt;
                        state <= ST_DONE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (abort || out_ready) begin
                        eq    <= 1'b0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    eq    <= 1'b0;
                    gt    <= 1'b0;
                    lt    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs are pure state decodes.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmp_seq_ctrl
// Self-checking bench for cmp_seq_ctrl (WIDTH=32, SLICE=8). A transaction
// level model predicts every output on every cycle; directed scenarios add
// literal expectations for flags, latency and handshake timing.
// ---------------------------------------------------------------------------
module tb_cmp_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cmp_seq_ctrl #(
        .WIDTH (32),
        .SLICE (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .busy      (busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of byte slices the block must look at: MSB-first up to and
    // including the first differing byte, or all four when equal.
    function automatic int slicesExamined(input logic [31:0] x, input logic [31:0] y);
        for (int s = 3; s >= 0; s--) begin
            if (((x >> (8 * s)) & 32'hFF) != ((y >> (8 * s)) & 32'hFF))
                return 4 - s;
        end
        return 4;
    endfunction

    // Reference unsigned compare, returned as {eq, gt, lt}.
    function automatic logic [2:0] refFlags(input logic [31:0] x, input logic [31:0] y);
        if (x == y) return 3'b100;
        if (x > y)  return 3'b010;
        return 3'b001;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction model: 0 = waiting for operands, 1 = comparing with
    // mLeft slice-cycles to go, 2 = holding a result.
    int         mPhase = 0;
    int         mLeft  = 0;
    logic [2:0] mFlags = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase <= 0;
            mLeft  <= 0;
            mFlags <= 3'b000;
        end else begin
            case (mPhase)
                0: if (in_valid) begin
                       mPhase <= 1;
                       mLeft  <= slicesExamined(a, b);
                       mFlags <= refFlags(a, b);
                   end
                1: if (abort)           mPhase <= 0;
                   else if (mLeft == 1) mPhase <= 2;
                   else                 mLeft  <= mLeft - 1;
                2: if (abort || out_ready) mPhase <= 0;
                default: mPhase <= 0;
            endcase
        end
    end

    // Every cycle, compare {in_ready, out_valid, busy, eq, gt, lt} with the
    // model away from the active edge.
    always @(negedge clk) begin
        logic [5:0] expVec;
        expVec = {mPhase == 0, mPhase == 2, mPhase != 0,
                  (mPhase == 2) ? mFlags : 3'b000};
        checkOutput("cycle", {26'b0, in_ready, out_valid, busy, eq, gt, lt}, {26'b0, expVec});
    end

    // Accept / delivery counters used to detect dropped or duplicated results.
    int accCount = 0;
    int delCount = 0;
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready)   accCount <= accCount + 1;
        if (rst_n && out_valid && out_ready) delCount <= delCount + 1;
    end

    // Offer one operand pair, wait for it to be accepted, then count cycles
    // from the accept edge until out_valid is seen (m+1 for m slices).
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, output int lat);
        int g;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Hand the result to the consumer and confirm IDLE the cycle after.
    task automatic releaseResult(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput(name, {31'b0, in_ready}, 32'd1);
    endtask

    logic [31:0] pa [100];
    logic [31:0] pb [100];
    bit          streamDone;

    initial begin
        int lat;
        int accBase;
        int delBase;
        int nextIdx;
        int guard;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        streamDone = 1'b0;
        #3 rst_n = 1'b0;
        #1 checkOutput("reset_state", {26'b0, in_ready, out_valid, busy, eq, gt, lt}, 32'b100000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed compares");
        applyStimulus(32'h12345678, 32'h12345679, lat);
        checkOutput("lt_flags", {29'b0, eq, gt, lt}, 32'b001);
        checkOutput("lt_latency", lat, 5);
        releaseResult("lt_release");

        applyStimulus(32'h80000000, 32'h7FFFFFFF, lat);
        checkOutput("gt_msb_flags", {29'b0, eq, gt, lt}, 32'b010);
        checkOutput("gt_msb_latency", lat, 2);
        releaseResult("gt_msb_release");

        applyStimulus(32'hDEADBEEF, 32'hDEADBEEF, lat);
        checkOutput("eq_flags", {29'b0, eq, gt, lt}, 32'b100);
        checkOutput("eq_latency", lat, 5);
        releaseResult("eq_release");

        applyStimulus(32'h0, 32'h0, lat);
        checkOutput("eq_zero_flags", {29'b0, eq, gt, lt}, 32'b100);
        checkOutput("eq_zero_latency", lat, 5);
        releaseResult("eq_zero_release");

        $display("[TB] result hold with consumer stalled");
        applyStimulus(32'h00120000, 32'h0011FFFF, lat);
        checkOutput("hold_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 32'hFFFFFFFF;
            b = 32'h00000000;
            @(negedge clk);
            checkOutput("hold_flags", {29'b0, eq, gt, lt}, 32'b010);
            checkOutput("hold_handshake", {30'b0, in_ready, out_valid}, 32'b01);
        end
        in_valid = 1'b0;
        releaseResult("hold_release");

        $display("[TB] abort in second RUN cycle");
        @(negedge clk);
        a = 32'h01000000;
        b = 32'h01000001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", {26'b0, in_ready, out_valid, busy, eq, gt, lt}, 32'b100000);
        repeat (5) begin
            @(negedge clk);
            checkOutput("abort_no_result", {31'b0, out_valid}, 32'd0);
        end

        $display("[TB] reset during RUN");
        a = 32'h01000000;
        b = 32'h01000001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("reset_mid_run", {26'b0, in_ready, out_valid, busy, eq, gt, lt}, 32'b100000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_no_result", {31'b0, out_valid}, 32'd0);
        end

        applyStimulus(32'd5, 32'd3, lat);
        checkOutput("after_reset_flags", {29'b0, eq, gt, lt}, 32'b010);
        checkOutput("after_reset_latency", lat, 5);
        releaseResult("after_reset_release");

        $display("[TB] random back-to-back stream");
        for (int i = 0; i < 100; i++) begin
            pa[i] = $urandom;
            case ($urandom_range(0, 3))
                0:       pb[i] = pa[i];
                1:       pb[i] = pa[i] ^ (32'h1 << $urandom_range(0, 31));
                2:       pb[i] = pa[i] ^ ($urandom & 32'hFF);
                default: pb[i] = $urandom;
            endcase
        end
        accBase = accCount;
        delBase = delCount;
        fork
            begin
                nextIdx = 0;
                guard = 0;
                @(negedge clk);
                a = pa[0];
                b = pb[0];
                in_valid = 1'b1;
                while ((accCount - accBase) < 100 && guard < 6000) begin
                    @(negedge clk);
                    guard++;
                    if ((accCount - accBase) > nextIdx) begin
                        nextIdx = accCount - accBase;
                        if (nextIdx < 100) begin
                            a = pa[nextIdx];
                            b = pb[nextIdx];
                        end else begin
                            in_valid = 1'b0;
                        end
                    end
                end
                in_valid = 1'b0;
                while ((delCount - delBase) < 100 && guard < 8000) begin
                    @(negedge clk);
                    guard++;
                end
                streamDone = 1'b1;
            end
            begin
                while (!streamDone) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checkOutput("stream_accepted", accCount - accBase, 100);
        checkOutput("stream_delivered", delCount - delBase, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
# cmp_seq_ctrl

Multi-cycle magnitude-compare controller. It time-shares one SLICE-bit comparator slice across a WIDTH-bit unsigned operand pair. Slices are evaluated MSB-first, and evaluation stops at the first unequal slice. The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It replaces a wide flat comparator where area matters more than latency.

## Interface
- WIDTH, 32: operand width in bits; must be an integer multiple of SLICE (elaboration error otherwise).
- SLICE, 8: bits compared per cycle. NSLICE = WIDTH/SLICE, minimum 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- abort  in  1  synchronous cancel of the current operation.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- eq, gt, lt  out  1 each  result flags; exactly one is high while out_valid=1.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: capture a and b into registers, set slice index idx=NSLICE-1, go to RUN.
- RUN
  - Compare captured slice [idx*SLICE +: SLICE] of A against the same slice of B.
  - Slice unequal: latch gt/lt from the slice, eq=0, go to DONE.
  - Slice equal and idx==0: latch eq=1, gt=0, lt=0, go to DONE.
  - Otherwise: decrement idx and stay in RUN.
- DONE
  - out_valid=1; flags are held stable.
  - On out_ready: go to IDLE and clear flags to 0.
- abort
  - High in RUN or DONE: go to IDLE next edge, clear flags, out_valid=0. No result is delivered.
  - Ignored in IDLE.
  - Takes priority over the slice result and over out_ready.
- Operand registers are loaded only on an accepted handshake. Input changes during RUN or DONE have no effect.
- in_valid during RUN or DONE is not accepted; in_ready=0.
- idx register width: clog2(NSLICE), minimum 1 bit.
- If NSLICE==1: RUN always exits after one cycle.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state to IDLE,
  - in_ready=1 (decoded from state),
  - out_valid=0, eq=0, gt=0, lt=0, busy=0,
  - idx=0, operand registers 0.
- Reset mid-operation discards the operation and delivers no result.
- Accept edge T0 puts the block in RUN for cycle T0+1.
- Define m = number of slices examined (1..NSLICE). out_valid rises in cycle T0+m+1, after m RUN edges.
- Latency from accept to out_valid: m+1 clocks. Best case 2, worst case NSLICE+1.
- Result handshake at edge Tr (out_valid&&out_ready): in_ready=1 in cycle Tr+1.
- Throughput: at most one compare per m+2 cycles. There is no overlap of accept with DONE.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid, a, b, or out_ready to any output.

## Structure
- Package cmp_pkg holds:
  - state typedef: enum of IDLE, RUN, DONE, 2-bit encoding,
  - default SLICE constant,
  - a function computing the idx width.
- Sub-module cmp_slice: purely combinational SLICE-bit comparator with outputs eq, gt, lt. Exactly one instance, muxed by idx.
- Controller FSM, idx counter, and operand/result registers live in cmp_seq_ctrl.

## Test plan
All scenarios use WIDTH=32, SLICE=8.
- a=0x12345678, b=0x12345679 -> lt=1, eq=0, gt=0; m=4, out_valid 5 cycles after accept.
- a=0x80000000, b=0x7FFFFFFF -> gt=1 after first slice; out_valid 2 cycles after accept.
- a=b=0xDEADBEEF -> eq=1 after 4 slices. Also a=b=0 -> eq=1.
- a=0x00120000, b=0x0011FFFF -> gt=1 with m=2.
  - Hold out_ready=0 for 5 cycles: flags and out_valid stay stable, in_ready=0.
  - New in_valid with different operands during this window is not accepted.
  - Release out_ready: in_ready=1 the next cycle.
- Abort and reset:
  - abort pulse in the 2nd RUN cycle of a=0x01000000, b=0x01000001 -> IDLE next cycle, no out_valid, flags 0.
  - Repeat with rst_n dropped mid-RUN -> all outputs reach reset values immediately.
  - A following compare of 5 vs 3 -> gt=1.
- Back-to-back stream of 100 random pairs with random out_ready -> every result matches the unsigned reference compare. No result is dropped or duplicated.
